// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter that funnels single-beat writes from NUM_REQ requesters into one AXI write channel.
// Optional WAIT_B watchdog is compiled in with the macro AXI_WRITE_ARB_TIMEOUT_EN.

package core_config;
    localparam int unsigned ADDR_WIDTH     = 32;
    localparam int unsigned AXI_DATA_WIDTH = 32;
    localparam int unsigned WS             = AXI_DATA_WIDTH / 8;
endpackage

module axi_write_arbiter
    import core_config::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_uncached,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*3-1:0]              req_size,
    input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*WS-1:0]             req_wstrb,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                req_done,
    output logic                              ch_new_request,
    output logic                              ch_uncached,
    output logic [ADDR_WIDTH-1:0]             ch_addr,
    output logic [2:0]                        ch_size,
    output logic [AXI_DATA_WIDTH-1:0]         ch_data,
    output logic [WS-1:0]                     ch_wstrb,
    input  logic                              ch_ready,
    input  logic                              ch_bvalid,
    output logic                              busy,
    output logic                              err_timeout
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_B = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               grant_any;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("axi_write_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    // Round-robin pick: scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
            if (req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (ch_ready && grant_any) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT_B;
            WAIT_B:  if (ch_bvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    // Command latch, response pulse and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_new_request <= 1'b0;
            ch_uncached    <= 1'b0;
            ch_addr        <= '0;
            ch_size        <= '0;
            ch_data        <= '0;
            ch_wstrb       <= '0;
            req_done       <= '0;
            busy           <= 1'b0;
            owner          <= '0;
            rr_ptr         <= '0;
        end else begin
            ch_new_request <= accept;
            busy           <= (state_nxt != IDLE);
            req_done       <= '0;
            if (accept) begin
                owner       <= grant_idx;
                ch_uncached <= req_uncached[grant_idx];
                ch_addr     <= req_addr[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                ch_size     <= req_size[32'(grant_idx)*3 +: 3];
                ch_data     <= req_data[32'(grant_idx)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                ch_wstrb    <= req_wstrb[32'(grant_idx)*WS +: WS];
            end
            if (state == WAIT_B && ch_bvalid) begin
                req_done <= NUM_REQ'(1) << owner;
                rr_ptr   <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
            end
        end
    end

`ifdef AXI_WRITE_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;

    // Watchdog restarts as WAIT_B is entered; the flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wd_cnt <= '0;
            end else if (state == WAIT_B && wd_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
            if (state == WAIT_B && wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Self-checking bench for axi_write_arbiter: directed scenarios plus a randomized run,
// every cycle compared against a transaction-level model of the arbiter.

module tb_axi_write_arbiter;
    import core_config::*;

    localparam int unsigned N  = 2;
    localparam int unsigned TO = 16;
    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned DW = AXI_DATA_WIDTH;
`ifdef AXI_WRITE_ARB_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_uncached = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*3-1:0]  req_size = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N*WS-1:0] req_wstrb = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_done;
    logic            ch_new_request, ch_uncached;
    logic [AW-1:0]   ch_addr;
    logic [2:0]      ch_size;
    logic [DW-1:0]   ch_data;
    logic [WS-1:0]   ch_wstrb;
    logic            ch_ready = 1'b1;
    logic            ch_bvalid = 1'b0;
    logic            busy, err_timeout;

    axi_write_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_uncached(req_uncached), .req_addr(req_addr),
        .req_size(req_size), .req_data(req_data), .req_wstrb(req_wstrb),
        .req_ready(req_ready), .req_done(req_done),
        .ch_new_request(ch_new_request), .ch_uncached(ch_uncached), .ch_addr(ch_addr),
        .ch_size(ch_size), .ch_data(ch_data), .ch_wstrb(ch_wstrb),
        .ch_ready(ch_ready), .ch_bvalid(ch_bvalid),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: who owns the channel (-1 = nobody), whether this is the command cycle,
    // how long the response has been awaited, and what the channel should be showing.
    int            m_owner = -1;
    bit            m_cmd   = 1'b0;
    int            m_wait  = 0;
    bit            m_err   = 1'b0;
    int            m_rr    = 0;
    logic [N-1:0]  m_done  = '0;
    logic          m_unc   = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [2:0]    m_size  = '0;
    logic [DW-1:0] m_data  = '0;
    logic [WS-1:0] m_strb  = '0;

    always @(negedge clk) begin : compare
        logic [N-1:0] exp_ready;
        int           w;
        exp_ready = '0;
        w = -1;
        if (m_owner < 0 && ch_ready) begin
            for (int k = 0; k < int'(N); k++) begin
                if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
            end
        end
        if (w >= 0) exp_ready[w] = 1'b1;
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_owner >= 0));
            check("ch_new_request", 64'(ch_new_request), 64'(m_cmd));
            check("ch_uncached", 64'(ch_uncached), 64'(m_unc));
            check("ch_addr", 64'(ch_addr), 64'(m_addr));
            check("ch_size", 64'(ch_size), 64'(m_size));
            check("ch_data", 64'(ch_data), 64'(m_data));
            check("ch_wstrb", 64'(ch_wstrb), 64'(m_strb));
            check("req_done", 64'(req_done), 64'(m_done));
            check("err_timeout", 64'(err_timeout), 64'(m_err));
            if (!rst) check("req_ready", 64'(req_ready), 64'(exp_ready));
        end
        m_done = '0;
        if (rst) begin
            m_owner = -1; m_cmd = 1'b0; m_wait = 0; m_err = 1'b0; m_rr = 0;
            m_unc = 1'b0; m_addr = '0; m_size = '0; m_data = '0; m_strb = '0;
        end else if (m_owner < 0) begin
            if (w >= 0) begin
                m_owner = w;
                m_cmd   = 1'b1;
                m_unc   = req_uncached[w];
                m_addr  = req_addr[w*AW +: AW];
                m_size  = req_size[w*3 +: 3];
                m_data  = req_data[w*DW +: DW];
                m_strb  = req_wstrb[w*WS +: WS];
            end
        end else if (m_cmd) begin
            m_cmd  = 1'b0;
            m_wait = 0;
        end else begin
            m_wait++;
            if (WD_EN && m_wait >= int'(TO)) m_err = 1'b1;
            if (ch_bvalid) begin
                m_done[m_owner] = 1'b1;
                m_rr    = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    end

    bit ch_pend = 1'b0;
    int ch_dly  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1; req_valid = '0; ch_bvalid = 1'b0; ch_ready = 1'b1; ch_pend = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic set_fields(input int i);
        req_uncached[i]       = 1'($urandom_range(0, 1));
        req_addr[i*AW +: AW]  = AW'($urandom);
        req_size[i*3 +: 3]    = 3'($urandom_range(0, 2));
        req_data[i*DW +: DW]  = DW'($urandom);
        req_wstrb[i*WS +: WS] = WS'($urandom_range(0, 15));
    endtask

    // One cycle of a responsive channel and requesters. mode 0: hold req_valid,
    // 1: random requesters, 2: drop accepted requests only.
    task automatic cycle_auto(input int mode, input bit allow_rst,
                              output logic [N-1:0] taken, output logic [N-1:0] done);
        @(negedge clk);
        taken = req_ready;
        done  = req_done;
        step();
        rst = 1'b0;
        ch_bvalid = 1'b0;
        if (ch_new_request) begin
            ch_pend = 1'b1; ch_dly = int'($urandom_range(0, 4)); ch_ready = 1'b0;
        end else if (ch_pend) begin
            ch_ready = 1'b0;
            if (ch_dly == 0) begin ch_bvalid = 1'b1; ch_pend = 1'b0; end
            else ch_dly--;
        end else begin
            ch_ready = ($urandom_range(0, 7) != 0);
            if (!busy && $urandom_range(0, 15) == 0) ch_bvalid = 1'b1;
        end
        for (int i = 0; i < int'(N); i++) begin
            if (mode == 1) begin
                if (!req_valid[i] || taken[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_fields(i);
                end
            end else if (mode == 2 && taken[i]) begin
                req_valid[i] = 1'b0;
            end
        end
        if (allow_rst && $urandom_range(0, 399) == 0) begin
            rst = 1'b1; ch_pend = 1'b0; ch_ready = 1'b1;
        end
    endtask

    logic [N-1:0] tk, dn;
    int           g[4];
    int           d[3];
    int           ng, nd;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        samp();
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(req_done), 64'(0));
        check("reset_new_request", 64'(ch_new_request), 64'(0));
        check("reset_addr", 64'(ch_addr), 64'(0));
        check("reset_err", 64'(err_timeout), 64'(0));

        // Single request with a response four cycles after the command.
        do_reset();
        req_valid = 2'b01; ch_ready = 1'b1;
        req_uncached[0] = 1'b0; req_addr[AW-1:0] = 32'h1C00_0040; req_size[2:0] = 3'd2;
        req_data[DW-1:0] = 32'hDEAD_BEEF; req_wstrb[WS-1:0] = 4'hF;
        samp();
        check("single_ready", 64'(req_ready), 64'(2'b01));
        step();
        req_valid = '0; ch_ready = 1'b0;
        samp();
        check("single_new_request", 64'(ch_new_request), 64'(1));
        check("single_addr", 64'(ch_addr), 64'(32'h1C00_0040));
        check("single_data", 64'(ch_data), 64'(32'hDEAD_BEEF));
        check("single_wstrb", 64'(ch_wstrb), 64'(4'hF));
        repeat (3) step();
        ch_bvalid = 1'b1;
        samp();
        check("single_no_early_done", 64'(req_done), 64'(0));
        step();
        ch_bvalid = 1'b0; ch_ready = 1'b1;
        samp();
        check("single_done", 64'(req_done), 64'(2'b01));
        check("single_idle", 64'(busy), 64'(0));

        // Both requesters held valid: grants must alternate.
        do_reset();
        req_valid = 2'b11; ch_ready = 1'b1;
        ng = 0; nd = 0;
        for (int c = 0; c < 200 && (ng < 4 || nd < 3); c++) begin
            cycle_auto(0, 1'b0, tk, dn);
            if (tk != '0 && ng < 4) begin g[ng] = tk[1] ? 1 : 0; ng++; end
            if (dn != '0 && nd < 3) begin d[nd] = dn[1] ? 1 : 0; nd++; end
        end
        check("rr_grant_count", 64'(ng), 64'(4));
        check("rr_done_count", 64'(nd), 64'(3));
        check("rr_grant0", 64'(g[0]), 64'(0));
        check("rr_grant1", 64'(g[1]), 64'(1));
        check("rr_grant2", 64'(g[2]), 64'(0));
        check("rr_grant3", 64'(g[3]), 64'(1));
        check("rr_done0", 64'(d[0]), 64'(0));
        check("rr_done1", 64'(d[1]), 64'(1));
        check("rr_done2", 64'(d[2]), 64'(0));
        for (int c = 0; c < 40; c++) cycle_auto(2, 1'b0, tk, dn);

        // Channel not ready: nothing is accepted until it comes back.
        do_reset();
        ch_ready = 1'b0; req_valid = 2'b11;
        for (int c = 0; c < 10; c++) begin
            samp();
            check("stall_ready", 64'(req_ready), 64'(0));
            check("stall_busy", 64'(busy), 64'(0));
            step();
        end
        ch_ready = 1'b1;
        samp();
        check("stall_release_ready", 64'(req_ready), 64'(2'b01));
        step();
        req_valid = '0; ch_ready = 1'b0; ch_pend = 1'b1; ch_dly = 2;
        for (int c = 0; c < 20; c++) cycle_auto(2, 1'b0, tk, dn);

        // Response pulse while idle is ignored.
        do_reset();
        ch_bvalid = 1'b1;
        step();
        ch_bvalid = 1'b0;
        samp();
        check("spurious_done", 64'(req_done), 64'(0));
        check("spurious_busy", 64'(busy), 64'(0));

        // Reset while waiting for a response abandons the write and clears the pointer.
        do_reset();
        req_valid = 2'b01; ch_ready = 1'b1;
        samp();
        check("rst_first_ready", 64'(req_ready), 64'(2'b01));
        step();
        req_valid = '0; ch_ready = 1'b0;
        step();
        ch_bvalid = 1'b1;
        step();
        ch_bvalid = 1'b0; ch_ready = 1'b1; req_valid = 2'b11;
        samp();
        check("rr_after_done_ready", 64'(req_ready), 64'(2'b10));
        check("done_with_grant", 64'(req_done), 64'(2'b01));
        step();
        req_valid = '0; ch_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        samp();
        check("rst_busy_before", 64'(busy), 64'(1));
        step();
        rst = 1'b0; ch_ready = 1'b1; req_valid = 2'b11;
        samp();
        check("rst_busy_after", 64'(busy), 64'(0));
        check("rst_no_done", 64'(req_done), 64'(0));
        check("rst_ptr_cleared", 64'(req_ready), 64'(2'b01));
        step();
        req_valid = '0; ch_ready = 1'b0;
        samp();
        check("rst_reissue", 64'(ch_new_request), 64'(1));
        step();
        ch_bvalid = 1'b1;
        step();
        ch_bvalid = 1'b0; ch_ready = 1'b1;
        samp();
        check("rst_reissue_done", 64'(req_done), 64'(2'b01));

        // No response for a long time: watchdog flag after TO waiting cycles.
        do_reset();
        req_valid = 2'b01; ch_ready = 1'b1;
        step();
        req_valid = '0; ch_ready = 1'b0;
        repeat (16) step();
        samp();
        check("wd_before_limit", 64'(err_timeout), 64'(0));
        step();
        samp();
        check("wd_at_limit", 64'(err_timeout), 64'(WD_EN));
        step();
        ch_bvalid = 1'b1;
        step();
        ch_bvalid = 1'b0; ch_ready = 1'b1;
        samp();
        check("wd_sticky", 64'(err_timeout), 64'(WD_EN));
        check("wd_late_done", 64'(req_done), 64'(2'b01));

        // Randomized traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) cycle_auto(1, 1'b1, tk, dn);
        for (int c = 0; c < 40; c++) cycle_auto(2, 1'b0, tk, dn);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
